mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multicycle control FSM for the 32-bit MIPS-subset datapath. Each cycle it drives every datapath select and write-enable, including the 3-bit ALU source-B select: 000 regB, 001 const 1, 010 const 4, 011 sign-extended immediate, 100 immediate<<2. It sequences fetch, decode, execute, memory and writeback for R-type add/sub/and, addi, lw, sw, beq and j. It traps on undefined instructions and on signed overflow.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- overflow  in  1  ALU signed-overflow flag, combinational, same cycle as ALU inputs
- zero  in  1  ALU zero flag (consumed by datapath pcWriteCond gating)
- pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, abWrite, aluOutWrite, mdrWrite, regWrite, regDst, memToReg, aluSrcA  out  1 each
- aluSrcB  out  3  encoding above
- aluOp  out  3  000 pass A, 001 add, 010 sub, 011 and
- pcSource  out  2  00 ALU result, 01 aluOut, 10 jump target {PC[31:28],IR[25:0],2'b00}
- trap  out  1  sticky fault indicator
- state  out  5  current state code, debug

## Operation
- Moore machine: outputs decode only from the registered state. Any signal not listed for a state is 0.
- RESET (0): all outputs 0. Next state is FETCH.
- FETCH (1): memRead, iorD=0, aluSrcA=0, aluSrcB=010, aluOp=001. Next: FETCH_WAIT.
- FETCH_WAIT (2): memRead, irWrite, pcWrite, pcSource=00, with the same ALU selects as FETCH (PC+4). Next: DECODE.
- DECODE (3): abWrite, aluOutWrite, aluSrcA=0, aluSrcB=100, aluOp=001 (branch target). Next state by opcode:
  - 0x00 → EXEC_R if funct ∈ {0x20, 0x22, 0x24}, otherwise TRAP.
  - 0x08 → EXEC_ADDI.
  - 0x23 or 0x2B → ADDR.
  - 0x04 → BRANCH.
  - 0x02 → JUMP.
  - any other opcode → TRAP.
- EXEC_R (4): aluSrcA=1, aluSrcB=000, aluOutWrite; aluOp is 001/010/011 for funct 0x20/0x22/0x24. Next: TRAP if overflow and funct≠0x24, else WB_R.
- WB_R (5): regWrite, regDst=1, memToReg=0. Next: FETCH.
- EXEC_ADDI (6): aluSrcA=1, aluSrcB=011, aluOp=001, aluOutWrite. Next: TRAP if overflow, else WB_ADDI.
- WB_ADDI (7): regWrite, regDst=0, memToReg=0. Next: FETCH.
- ADDR (8): aluSrcA=1, aluSrcB=011, aluOp=001, aluOutWrite. Next: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ (9): memRead, iorD=1. Next: MEM_WAIT.
- MEM_WAIT (10): memRead, iorD=1, mdrWrite. Next: WB_LW.
- WB_LW (11): regWrite, regDst=0, memToReg=1. Next: FETCH.
- MEM_WRITE (12): memWrite, iorD=1. Next: FETCH.
- BRANCH (13): aluSrcA=1, aluSrcB=000, aluOp=010, pcWriteCond, pcSource=01. Next: FETCH.
- JUMP (14): pcWrite, pcSource=10. Next: FETCH.
- TRAP (15): trap=1, all write enables 0. Stays in TRAP until reset.
- Overflow is ignored in every state except EXEC_R (add/sub only) and EXEC_ADDI.
- opcode/funct are ignored outside DECODE, EXEC_R and ADDR.

## Timing
- Reset is sampled on the clk edge: state becomes RESET on the next edge, and outputs are 0 in that cycle.
- Reset has priority over every transition, including mid-instruction and while in TRAP. A partially executed instruction is abandoned with no further writes.
- After reset deasserts, RESET lasts 1 cycle, then FETCH.
- Cycles per instruction, counted from the FETCH entry:
  - R-type 5, addi 5, sw 5
  - lw 7
  - beq 4, j 4
- The next FETCH follows immediately after the final state, with no idle cycle.
- Outputs change only after clk edges; no combinational path from inputs to outputs.
- Memory read data is assumed valid at the end of the second memRead cycle (FETCH_WAIT, MEM_WAIT).

## Test plan
- Reset, then add (op 0x00, funct 0x20, overflow=0): state sequence 0,1,2,3,4,5,1. aluSrcB=010 in FETCH, 100 in DECODE, 000 in EXEC_R. regWrite=1 only in WB_R.
- lw (0x23): states 1,2,3,8,9,10,11,1. aluSrcB=011 in ADDR, mdrWrite in state 10, memToReg=1 in state 11. sw (0x2B): memWrite in state 12 only, regWrite never 1.
- beq (0x04): pcWriteCond=1 with aluOp=010 in state 13. j (0x02): pcWrite=1 with pcSource=10 in state 14. Both return to FETCH after 4 cycles.
- addi with overflow=1 in EXEC_ADDI → TRAP, trap=1 held for 10+ cycles, regWrite never asserted. Same stimulus on R-type and (0x24) → WB_R, no trap.
- Undefined opcode 0x3F, and R-type funct 0x27 → TRAP directly from DECODE.
- Assert reset during MEM_READ and again while in TRAP → RESET next cycle with all outputs 0, then FETCH; trap cleared.

Source files
------------

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/writeback and traps faults.
// Outputs are registered Moore decodes of the current state; opcode/funct/overflow affect the next state only.
// No handshake: advances one state every clock, reset has priority over every transition.
module mc_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       overflow,
  input  logic       zero,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       abWrite,
  output logic       aluOutWrite,
  output logic       mdrWrite,
  output logic       regWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       aluSrcA,
  output logic [2:0] aluSrcB,
  output logic [2:0] aluOp,
  output logic [1:0] pcSource,
  output logic       trap,
  output logic [4:0] state
);

  typedef enum logic [4:0] {
    S_RESET      = 5'd0,
    S_FETCH      = 5'd1,
    S_FETCH_WAIT = 5'd2,
    S_DECODE     = 5'd3,
    S_EXEC_R     = 5'd4,
    S_WB_R       = 5'd5,
    S_EXEC_ADDI  = 5'd6,
    S_WB_ADDI    = 5'd7,
    S_ADDR       = 5'd8,
    S_MEM_READ   = 5'd9,
    S_MEM_WAIT   = 5'd10,
    S_WB_LW      = 5'd11,
    S_MEM_WRITE  = 5'd12,
    S_BRANCH     = 5'd13,
    S_JUMP       = 5'd14,
    S_TRAP       = 5'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       ab_write;
    logic       alu_out_write;
    logic       mdr_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       trap;
  } ctl_t;

  state_t st;
  state_t nxt;
  ctl_t   ctl;

  // The zero flag gates pcWriteCond inside the datapath; the FSM never needs it.
  logic unused_zero;
  assign unused_zero = zero;

  logic rtype_ok;
  assign rtype_ok = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24);

  // Control word for a state; funct only matters for the R-type ALU operation.
  function automatic ctl_t decode(input state_t s, input logic [5:0] fn);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read = 1'b1; c.alu_src_b = 3'b010; c.alu_op = 3'b001;
      end
      S_FETCH_WAIT: begin
        c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
        c.alu_src_b = 3'b010; c.alu_op = 3'b001;
      end
      S_DECODE: begin
        c.ab_write = 1'b1; c.alu_out_write = 1'b1; c.alu_src_b = 3'b100; c.alu_op = 3'b001;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1; c.alu_out_write = 1'b1;
        c.alu_op = (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b001;
      end
      S_WB_R:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_EXEC_ADDI, S_ADDR: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 3'b011; c.alu_op = 3'b001; c.alu_out_write = 1'b1;
      end
      S_WB_ADDI:   c.reg_write = 1'b1;
      S_MEM_READ:  begin c.mem_read = 1'b1; c.ior_d = 1'b1; end
      S_MEM_WAIT:  begin c.mem_read = 1'b1; c.ior_d = 1'b1; c.mdr_write = 1'b1; end
      S_WB_LW:     begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEM_WRITE: begin c.mem_write = 1'b1; c.ior_d = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_op = 3'b010; c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
      end
      S_JUMP:    begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      S_TRAP:    c.trap = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection; overflow only counts in add/sub and addi execute.
  always_comb begin
    nxt = st;
    case (st)
      S_RESET:      nxt = S_FETCH;
      S_FETCH:      nxt = S_FETCH_WAIT;
      S_FETCH_WAIT: nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          6'h00:        nxt = rtype_ok ? S_EXEC_R : S_TRAP;
          6'h08:        nxt = S_EXEC_ADDI;
          6'h23, 6'h2B: nxt = S_ADDR;
          6'h04:        nxt = S_BRANCH;
          6'h02:        nxt = S_JUMP;
          default:      nxt = S_TRAP;
        endcase
      end
      S_EXEC_R:     nxt = (overflow && (funct != 6'h24)) ? S_TRAP : S_WB_R;
      S_WB_R:       nxt = S_FETCH;
      S_EXEC_ADDI:  nxt = overflow ? S_TRAP : S_WB_ADDI;
      S_WB_ADDI:    nxt = S_FETCH;
      S_ADDR:       nxt = (opcode == 6'h2B) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:   nxt = S_MEM_WAIT;
      S_MEM_WAIT:   nxt = S_WB_LW;
      S_WB_LW:      nxt = S_FETCH;
      S_MEM_WRITE:  nxt = S_FETCH;
      S_BRANCH:     nxt = S_FETCH;
      S_JUMP:       nxt = S_FETCH;
      S_TRAP:       nxt = S_TRAP;
      default:      nxt = S_TRAP;
    endcase
  end

  // State and its control word registered together so outputs never see input glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= S_RESET;
      ctl <= '0;
    end else begin
      st  <= nxt;
      ctl <= decode(nxt, funct);
    end
  end

  assign pcWrite     = ctl.pc_write;
  assign pcWriteCond = ctl.pc_write_cond;
  assign iorD        = ctl.ior_d;
  assign memRead     = ctl.mem_read;
  assign memWrite    = ctl.mem_write;
  assign irWrite     = ctl.ir_write;
  assign abWrite     = ctl.ab_write;
  assign aluOutWrite = ctl.alu_out_write;
  assign mdrWrite    = ctl.mdr_write;
  assign regWrite    = ctl.reg_write;
  assign regDst      = ctl.reg_dst;
  assign memToReg    = ctl.mem_to_reg;
  assign aluSrcA     = ctl.alu_src_a;
  assign aluSrcB     = ctl.alu_src_b;
  assign aluOp       = ctl.alu_op;
  assign pcSource    = ctl.pc_source;
  assign trap        = ctl.trap;
  assign state       = st;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: expected state/control words queued per instruction.
// Each queued entry is compared one cycle later, sampled 1 time unit after the rising edge.
// Inputs are driven while the DUT sits in FETCH; opcode/funct/overflow held for the whole instruction.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       overflow, zero;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, abWrite;
  logic       aluOutWrite, mdrWrite, regWrite, regDst, memToReg, aluSrcA, trap;
  logic [2:0] aluSrcB, aluOp;
  logic [1:0] pcSource;
  logic [4:0] state;

  mc_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .overflow(overflow), .zero(zero),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .abWrite(abWrite), .aluOutWrite(aluOutWrite),
    .mdrWrite(mdrWrite), .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource),
    .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  // Observed control word: 13 flags, aluSrcB, aluOp, pcSource, trap.
  logic [21:0] obs;
  assign obs = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, abWrite, aluOutWrite,
                mdrWrite, regWrite, regDst, memToReg, aluSrcA, aluSrcB, aluOp, pcSource, trap};

  typedef struct packed {
    logic [4:0]  st;
    logic [21:0] v;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference control word per state, straight from the state table.
  function automatic logic [21:0] ref_ctl(input int s, input logic [5:0] fn);
    logic [2:0] rop;
    rop = (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b001;
    case (s)
      1:  return {13'b0_0_0_1_0_0_0_0_0_0_0_0_0, 3'b010, 3'b001, 2'b00, 1'b0};
      2:  return {13'b1_0_0_1_0_1_0_0_0_0_0_0_0, 3'b010, 3'b001, 2'b00, 1'b0};
      3:  return {13'b0_0_0_0_0_0_1_1_0_0_0_0_0, 3'b100, 3'b001, 2'b00, 1'b0};
      4:  return {13'b0_0_0_0_0_0_0_1_0_0_0_0_1, 3'b000, rop,    2'b00, 1'b0};
      5:  return {13'b0_0_0_0_0_0_0_0_0_1_1_0_0, 3'b000, 3'b000, 2'b00, 1'b0};
      6:  return {13'b0_0_0_0_0_0_0_1_0_0_0_0_1, 3'b011, 3'b001, 2'b00, 1'b0};
      7:  return {13'b0_0_0_0_0_0_0_0_0_1_0_0_0, 3'b000, 3'b000, 2'b00, 1'b0};
      8:  return {13'b0_0_0_0_0_0_0_1_0_0_0_0_1, 3'b011, 3'b001, 2'b00, 1'b0};
      9:  return {13'b0_0_1_1_0_0_0_0_0_0_0_0_0, 3'b000, 3'b000, 2'b00, 1'b0};
      10: return {13'b0_0_1_1_0_0_0_0_1_0_0_0_0, 3'b000, 3'b000, 2'b00, 1'b0};
      11: return {13'b0_0_0_0_0_0_0_0_0_1_0_1_0, 3'b000, 3'b000, 2'b00, 1'b0};
      12: return {13'b0_0_1_0_1_0_0_0_0_0_0_0_0, 3'b000, 3'b000, 2'b00, 1'b0};
      13: return {13'b0_1_0_0_0_0_0_0_0_0_0_0_1, 3'b000, 3'b010, 2'b01, 1'b0};
      14: return {13'b1_0_0_0_0_0_0_0_0_0_0_0_0, 3'b000, 3'b000, 2'b10, 1'b0};
      15: return {13'b0, 3'b000, 3'b000, 2'b00, 1'b1};
      default: return 22'd0;
    endcase
  endfunction

  task automatic push(input int s);
    exp_t e;
    e.st = s[4:0];
    e.v  = ref_ctl(s, funct);
    q.push_back(e);
  endtask

  task automatic push_trap();
    for (int i = 0; i < 12; i++) push(15);
  endtask

  // Expected state walk for one instruction starting from FETCH.
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic ovf);
    push(2); push(3);
    case (op)
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24) begin
          push(4);
          if (ovf && fn != 6'h24) push_trap();
          else begin push(5); push(1); end
        end else push_trap();
      end
      6'h08: begin
        push(6);
        if (ovf) push_trap();
        else begin push(7); push(1); end
      end
      6'h23: begin push(8); push(9); push(10); push(11); push(1); end
      6'h2B: begin push(8); push(12); push(1); end
      6'h04: begin push(13); push(1); end
      6'h02: begin push(14); push(1); end
      default: push_trap();
    endcase
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      chk($sformatf("state(exp %0d)", e.st), {27'd0, state}, {27'd0, e.st});
      chk($sformatf("ctl(st %0d)", e.st), {10'd0, obs}, {10'd0, e.v});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; push(0); drain();
    reset = 1'b0; push(1); drain();
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic ovf);
    opcode = op; funct = fn; overflow = ovf;
    push_instr(op, fn, ovf);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; opcode = 6'h00; funct = 6'h00; overflow = 1'b0; zero = 1'b0;
    @(posedge clk); #1;
    do_reset();

    instr(6'h00, 6'h20, 1'b0);   // add
    instr(6'h23, 6'h00, 1'b1);   // lw, overflow must be ignored
    instr(6'h2B, 6'h11, 1'b1);   // sw, overflow ignored
    instr(6'h04, 6'h00, 1'b0);   // beq
    zero = 1'b1;
    instr(6'h02, 6'h00, 1'b1);   // j
    instr(6'h00, 6'h22, 1'b0);   // sub
    instr(6'h00, 6'h24, 1'b1);   // and with overflow flag: no trap
    instr(6'h08, 6'h3F, 1'b0);   // addi
    zero = 1'b0;

    instr(6'h08, 6'h00, 1'b1);   // addi overflow -> trap held
    do_reset();                  // reset while trapped
    instr(6'h3F, 6'h20, 1'b0);   // undefined opcode
    do_reset();
    instr(6'h00, 6'h27, 1'b0);   // undefined funct
    do_reset();
    instr(6'h00, 6'h22, 1'b1);   // sub overflow -> trap
    do_reset();

    // lw abandoned in MEM_READ by reset
    opcode = 6'h23; funct = 6'h00; overflow = 1'b0;
    push(2); push(3); push(8); push(9);
    drain();
    do_reset();
    instr(6'h00, 6'h20, 1'b0);   // machine still works afterwards

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
